// File: rtl/key_debounce_multi.sv
// ---------------------------------------------------------------------------
// key_debounce_multi
//
// N-channel push-button debouncer. One shared 1 ms tick prescaler drives
// every channel. Each channel has its own 2-FF synchroniser, a two-state
// debounce FSM with a tick counter, and registered press/release pulses
// plus a toggle output.
//
// Optional feature (macro KEY_LONG_PRESS_EN):
//   defined   - each channel gets a hold counter and emits one Long_Pulse
//               per press once the key has been held for LONG_MS ticks.
//   undefined - no hold counters; Long_Pulse is tied to 0.
//
// Ports:
//   CLK            in   1       system clock
//   RST            in   1       asynchronous, active-high reset
//   Key_In         in   N_KEYS  raw asynchronous key pins
//   Key_Level      out  N_KEYS  debounced level (same polarity as the pin)
//   Press_Pulse    out  N_KEYS  one-cycle pulse on an accepted press
//   Release_Pulse  out  N_KEYS  one-cycle pulse on an accepted release
//   Toggle_Out     out  N_KEYS  flips on every accepted press
//   Long_Pulse     out  N_KEYS  one-cycle pulse on a long press
// ---------------------------------------------------------------------------
module key_debounce_multi #(
   parameter int N_KEYS      = 4,
   parameter int TICK_DIV    = 49999,
   parameter int DEBOUNCE_MS = 20,
   parameter int ACTIVE_LOW  = 1,
   parameter int LONG_MS     = 1000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_KEYS-1:0] Key_In,
   output logic [N_KEYS-1:0] Key_Level,
   output logic [N_KEYS-1:0] Press_Pulse,
   output logic [N_KEYS-1:0] Release_Pulse,
   output logic [N_KEYS-1:0] Toggle_Out,
   output logic [N_KEYS-1:0] Long_Pulse
);

   localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
   localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;

   localparam logic [PW-1:0] TICK_TC  = PW'(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

   // Pin level of a released key.
   localparam logic IDLE_BIT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CHECK = 1'b1;

   // Empty marker block: an out-of-range parameter set shows up under this
   // name in the elaborated hierarchy.
   if (N_KEYS < 1 || DEBOUNCE_MS < 1 || LONG_MS < 1 || TICK_DIV < 0) begin : g_param_range_error
   end

   // ------------------------------------------------------------------
   // Shared prescaler: w_tick is high for the single cycle at TICK_DIV.
   // ------------------------------------------------------------------
   logic [PW-1:0] r_presc;
   logic          w_tick;

   assign w_tick = (r_presc == TICK_TC);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Two-stage synchroniser, reset to the idle pin level so a key held
   // through reset is seen as a fresh change afterwards.
   // ------------------------------------------------------------------
   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync1 <= {N_KEYS{IDLE_BIT}};
         r_sync2 <= {N_KEYS{IDLE_BIT}};
      end else begin
         r_sync1 <= Key_In;
         r_sync2 <= r_sync1;
      end
   end

   // ------------------------------------------------------------------
   // Per-channel debounce FSM, pulse generation and optional hold counter.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      logic [0:0]    r_state;
      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          r_level_d;
      logic          r_press;
      logic          r_release;
      logic          r_toggle;
      logic          w_sync;
      logic          w_diff;
      logic          w_rise_act;
      logic          w_fall_idle;

      assign w_sync = r_sync2[gi];
      assign w_diff = (w_sync != r_level);

      // Edges of the committed level, seen one cycle late so the pulses
      // come straight out of a register.
      assign w_rise_act  = (r_level_d == IDLE_BIT) && (r_level != IDLE_BIT);
      assign w_fall_idle = (r_level_d != IDLE_BIT) && (r_level == IDLE_BIT);

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_level   <= IDLE_BIT;
            r_level_d <= IDLE_BIT;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
                  if (w_diff) begin
                     r_state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  // A bounce back to the committed level wins over a tick
                  // landing in the same cycle.
                  if (!w_diff) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end else if (w_tick) begin
                     if (r_cnt == CNT_LAST) begin
                        r_level <= w_sync;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase

            r_level_d <= r_level;
            r_press   <= w_rise_act;
            r_release <= w_fall_idle;
            if (w_rise_act) begin
               r_toggle <= ~r_toggle;
            end
         end
      end

      assign Key_Level[gi]     = r_level;
      assign Press_Pulse[gi]   = r_press;
      assign Release_Pulse[gi] = r_release;
      assign Toggle_Out[gi]    = r_toggle;

`ifdef KEY_LONG_PRESS_EN
      localparam int HW = (LONG_MS > 1) ? $clog2(LONG_MS + 1) : 1;
      localparam logic [HW-1:0] HOLD_TC   = HW'(LONG_MS);
      localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);

      logic [HW-1:0] r_hold;
      logic          r_long;

      // Counts ticks while the debounced level is active and parks at
      // LONG_MS, so the pulse fires only on the step that reaches it.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            r_hold <= '0;
            r_long <= 1'b0;
         end else begin
            r_long <= 1'b0;
            if (r_level == IDLE_BIT) begin
               r_hold <= '0;
            end else if (w_tick && (r_hold != HOLD_TC)) begin
               r_hold <= r_hold + HW'(1);
               r_long <= (r_hold == HOLD_LAST);
            end
         end
      end

      assign Long_Pulse[gi] = r_long;
`else
      assign Long_Pulse[gi] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

   localparam int NK = 2;
   localparam int TD = 9;
   localparam int TP = TD + 1;
   localparam int DB = 3;
   localparam int LM = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_in = '1;
   logic [NK-1:0] key_level;
   logic [NK-1:0] press_pulse;
   logic [NK-1:0] release_pulse;
   logic [NK-1:0] toggle_out;
   logic [NK-1:0] long_pulse;

   key_debounce_multi #(
      .N_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_MS(DB), .ACTIVE_LOW(1), .LONG_MS(LM)
   ) dut (
      .CLK(clk), .RST(rst), .Key_In(key_in),
      .Key_Level(key_level), .Press_Pulse(press_pulse),
      .Release_Pulse(release_pulse), .Toggle_Out(toggle_out),
      .Long_Pulse(long_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [NK-1:0] press;
      logic [NK-1:0] rel;
      logic [NK-1:0] lng;
      logic [NK-1:0] tog;
      logic [NK-1:0] lvl;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   // Observed DUT events, used by the directed checks.
   int n_pulse_ev = 0;
   int n_press[NK];
   int n_long[NK];
   int last_press[NK];
   int last_long[NK];

   task automatic chk_eq(input string nm, input int act, input int exp_v);
      checks++;
      if (act == exp_v) passes++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act >= lo && act <= hi) passes++;
      else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
   endtask

   // ------------------------------------------------------------------
   // Reference model. Rules:
   //  - the debouncer sees Key_In two edges late (idle after reset);
   //  - a change is accepted on the tick edge where DB ticks have occurred
   //    after the first edge on which the delayed input disagreed with the
   //    accepted level, provided it disagreed on every edge since;
   //  - pulses / toggle appear one edge after acceptance;
   //  - long pulse: tick edge exactly LM ticks after a press was accepted
   //    while still pressed.
   // Ticks are the edges k (counted from reset release) with k % TP == 0.
   // ------------------------------------------------------------------
   int            m_edges;
   logic [NK-1:0] m_d1, m_d2, m_level, m_tog, m_pend_act, m_pend_idle;
   logic [NK-1:0] e_press, e_rel, e_long, n_level;
   bit            m_in_run[NK];
   int            m_run_start[NK];
   int            m_active_since[NK];
   bit            m_tick;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (rst) begin
            m_edges = 0;
            m_d1 = '1; m_d2 = '1; m_level = '1; m_tog = '0;
            m_pend_act = '0; m_pend_idle = '0;
            for (int c = 0; c < NK; c++) begin
               m_in_run[c] = 0; m_run_start[c] = 0; m_active_since[c] = 0;
            end
         end else begin
            m_edges = m_edges + 1;
            m_tick  = (m_edges % TP) == 0;
            e_press = m_pend_act;
            e_rel   = m_pend_idle;
            m_tog   = m_tog ^ e_press;
            e_long  = '0;
            m_pend_act = '0; m_pend_idle = '0;
            n_level = m_level;
            for (int c = 0; c < NK; c++) begin
`ifdef KEY_LONG_PRESS_EN
               if (m_level[c] == 1'b0 && m_tick &&
                   (m_edges / TP - m_active_since[c] / TP) == LM)
                  e_long[c] = 1'b1;
`endif
               if (m_d2[c] != m_level[c]) begin
                  if (!m_in_run[c]) begin
                     m_in_run[c] = 1; m_run_start[c] = m_edges;
                  end else if (m_tick && (m_edges / TP - m_run_start[c] / TP) == DB) begin
                     n_level[c] = m_d2[c];
                     m_in_run[c] = 0;
                     if (m_d2[c] == 1'b0) begin
                        m_pend_act[c] = 1'b1; m_active_since[c] = m_edges;
                     end else begin
                        m_pend_idle[c] = 1'b1;
                     end
                  end
               end else begin
                  m_in_run[c] = 0;
               end
            end
            m_level = n_level;
            m_d2 = m_d1;
            m_d1 = key_in;
            if ((e_press | e_rel | e_long) != '0)
               sb.push_back('{cyc, e_press, e_rel, e_long, m_tog, m_level});
         end
      end
   end

   // ------------------------------------------------------------------
   // Monitor: whenever the DUT shows any pulse, pop and compare.
   // ------------------------------------------------------------------
   initial begin
      exp_t e;
      for (int c = 0; c < NK; c++) begin
         n_press[c] = 0; n_long[c] = 0; last_press[c] = -1; last_long[c] = -1;
      end
      forever begin
         @(posedge clk);
         #2;
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            $display("FAIL missed_event: expected pulses at cycle %0d (press=%b rel=%b long=%b), DUT showed no pulse",
                     sb[0].cyc, sb[0].press, sb[0].rel, sb[0].lng);
            void'(sb.pop_front());
         end
         if ((press_pulse | release_pulse | long_pulse) != '0) begin
            n_pulse_ev++;
            for (int c = 0; c < NK; c++) begin
               if (press_pulse[c]) begin n_press[c]++; last_press[c] = cyc; end
               if (long_pulse[c])  begin n_long[c]++;  last_long[c]  = cyc; end
            end
            checks++;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
               $display("FAIL unexpected_event: cycle %0d got press=%b rel=%b long=%b, no event expected",
                        cyc, press_pulse, release_pulse, long_pulse);
            end else begin
               e = sb.pop_front();
               if (e.press == press_pulse && e.rel == release_pulse && e.lng == long_pulse &&
                   e.tog == toggle_out && e.lvl == key_level) begin
                  passes++;
                  $display("event cyc=%0d press=%b rel=%b long=%b tog=%b lvl=%b ok",
                           cyc, press_pulse, release_pulse, long_pulse, toggle_out, key_level);
               end else begin
                  $display("FAIL event_cmp cyc=%0d got press=%b rel=%b long=%b tog=%b lvl=%b want press=%b rel=%b long=%b tog=%b lvl=%b",
                           cyc, press_pulse, release_pulse, long_pulse, toggle_out, key_level,
                           e.press, e.rel, e.lng, e.tog, e.lvl);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus and directed checks.
   // ------------------------------------------------------------------
   initial begin
      int ev0, p0, p1, t0, tr, lp0;

      rst = 1'b1; key_in = '1;
      repeat (5) @(negedge clk);
      chk_eq("reset_level", int'(key_level), 3);
      chk_eq("reset_toggle", int'(toggle_out), 0);
      chk_eq("reset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
      rst = 1'b0;
      ev0 = n_pulse_ev;
      repeat (200) @(negedge clk);
      chk_eq("idle_no_pulse", n_pulse_ev - ev0, 0);

      // Clean press on key 0.
      key_in[0] = 1'b0; t0 = cyc; p0 = n_press[0]; p1 = n_press[1];
      repeat (60) @(negedge clk);
      chk_eq("clean_press_count", n_press[0] - p0, 1);
      chk_rng("clean_press_latency", last_press[0] - (t0 + 1), 23, 33);
      chk_eq("clean_level", int'(key_level), 2);
      chk_eq("clean_toggle0", int'(toggle_out[0]), 1);
      chk_eq("clean_ch1_quiet", n_press[1] - p1, 0);
      key_in[0] = 1'b1;
      repeat (60) @(negedge clk);

      // Bounce on key 0: 7-cycle segments never hold long enough.
      ev0 = n_pulse_ev;
      for (int i = 0; i < 100; i++) begin
         if (i % 7 == 0) key_in[0] = ~key_in[0];
         @(negedge clk);
      end
      key_in[0] = 1'b1;
      repeat (60) @(negedge clk);
      chk_eq("bounce_no_pulse", n_pulse_ev - ev0, 0);
      chk_eq("bounce_level0", int'(key_level[0]), 1);

      // Simultaneous press of both keys.
      p0 = n_press[0]; p1 = n_press[1];
      key_in = 2'b00;
      repeat (60) @(negedge clk);
      chk_eq("simul_press0", n_press[0] - p0, 1);
      chk_eq("simul_press1", n_press[1] - p1, 1);
      chk_eq("simul_same_cycle", last_press[0] - last_press[1], 0);
      key_in = 2'b11;
      repeat (60) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         key_in[0] = 1'b0; repeat (60) @(negedge clk);
         key_in[0] = 1'b1; repeat (60) @(negedge clk);
      end
      chk_eq("toggle0_even", int'(toggle_out[0]), 0);
      chk_eq("toggle1_odd", int'(toggle_out[1]), 1);

      // Reset in the middle of a debounce check, key held through it.
      ev0 = n_pulse_ev;
      key_in[0] = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      chk_eq("rst_mid_no_pulse", n_pulse_ev - ev0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0; tr = cyc; p0 = n_press[0];
      repeat (60) @(negedge clk);
      chk_eq("rst_mid_press_count", n_press[0] - p0, 1);
      chk_rng("rst_mid_press_delay", last_press[0] - tr, DB * TP, DB * TP + TP);
      key_in[0] = 1'b1;
      repeat (60) @(negedge clk);

      // Long press on key 0.
      lp0 = n_long[0];
      key_in[0] = 1'b0;
      repeat (200) @(negedge clk);
`ifdef KEY_LONG_PRESS_EN
      chk_eq("long_count", n_long[0] - lp0, 1);
      chk_rng("long_delay", last_long[0] - last_press[0], 78, 82);
`else
      chk_eq("long_absent", n_long[0] - lp0, 0);
`endif
      key_in[0] = 1'b1;
      repeat (60) @(negedge clk);

      // Randomised segments checked by the scoreboard.
      for (int s = 0; s < 150; s++) begin
         key_in = NK'($urandom_range(0, 3));
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      key_in = '1;
      repeat (100) @(negedge clk);
      chk_eq("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
